serial_logic_unit: RTL and testbench

//   Multi-cycle, slice-serial logic unit for the MIPS datapath: the sequential

---
 rtl/serial_logic_unit.sv | 124 ++++++++++++
 tb/tb_serial_logic_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_logic_unit.sv
// Slice-serial AND/OR/XOR/NOR unit. Operands are consumed SLICE bits per clock,
// LSB first. The finished word is published with a one-cycle done pulse.

module serial_logic_bit (
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);
  always_comb begin
    y = 1'b0;
    case (op)
      2'b00: y = a & b;
      2'b01: y = a | b;
      2'b10: y = a ^ b;
      2'b11: y = ~(a | b);
      default: y = 1'b0;
    endcase
  end
endmodule

module serial_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((SLICE != 1 && SLICE != 2 && SLICE != 4 && SLICE != 8) || (WIDTH % SLICE != 0)) begin : g_bad_param
    $error("serial_logic_unit: SLICE must be 1/2/4/8 and divide WIDTH");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;
  logic [SLICE-1:0] slice_out;
  logic [WIDTH-1:0] word_nxt;
  logic             accept, last;

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CW'(N - 1));

  // One evaluator per bit of the slice; no carries, so lanes are independent.
  for (genvar i = 0; i < SLICE; i++) begin : g_lane
    serial_logic_bit u_bit (
      .op (op_q),
      .a  (a_sr[i]),
      .b  (b_sr[i]),
      .y  (slice_out[i])
    );
  end

  // New slice enters at the top; after N shifts bit i lands at position i.
  if (N > 1) begin : g_shift
    assign word_nxt = {slice_out, res_sr[WIDTH-1:SLICE]};
  end else begin : g_single
    assign word_nxt = slice_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      op_q   <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sr   <= a;
        b_sr   <= b;
        op_q   <= op;
        cnt    <= '0;
        res_sr <= '0;
      end else if (state == BUSY) begin
        a_sr   <= a_sr >> SLICE;
        b_sr   <= b_sr >> SLICE;
        res_sr <= word_nxt;
        cnt    <= cnt + CW'(1);
        // result/zero only move here so partial words never leak out
        if (last) begin
          result <= word_nxt;
          zero   <= (word_nxt == '0);
          done   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit at SLICE=1 and SLICE=4, scoreboarded
// on done pulses against a per-bit logic model.

module tb_serial_logic_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic [1:0]  op1 = '0, op4 = '0;
  logic [31:0] a1 = '0, b1 = '0, a4 = '0, b4 = '0;
  logic        busy1, done1, zero1, busy4, done4, zero4;
  logic [31:0] result1, result4;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [31:0] r; logic z; } exp_t;
  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  serial_logic_unit #(.WIDTH(32), .SLICE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(result1), .zero(zero1));

  serial_logic_unit #(.WIDTH(32), .SLICE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .zero(zero4));

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected word.
  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) check("s1_unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        check("s1_result", result1, e.r);
        check("s1_zero", {31'd0, zero1}, {31'd0, e.z});
        check("s1_busy_at_done", {31'd0, busy1}, 32'd0);
      end
    end
    if (rst_n && done4) begin
      if (q4.size() == 0) check("s4_unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q4.pop_front();
        check("s4_result", result4, e.r);
        check("s4_zero", {31'd0, zero4}, {31'd0, e.z});
      end
    end
  end

  task automatic push(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.r = model(op, a, b);
    e.z = (e.r == 32'd0);
    if (d == 1) q1.push_back(e); else q4.push_back(e);
  endtask

  task automatic drive(input int d, input logic s, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (d == 1) begin start1 = s; op1 = op; a1 = a; b1 = b; end
    else        begin start4 = s; op4 = op; a4 = a; b4 = b; end
  endtask

  // Accept edge E0 is the posedge this task waits on; returns #1 after it.
  task automatic start_op(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive(d, 1'b1, op, a, b);
    @(posedge clk);
    #1;
    if (d == 1) start1 = 1'b0; else start4 = 1'b0;
    push(d, op, a, b);
    check(d == 1 ? "s1_busy_after_accept" : "s4_busy_after_accept",
          {31'd0, (d == 1) ? busy1 : busy4}, 32'd1);
  endtask

  // Counts posedges after E0 until done is seen; that count is the latency.
  task automatic wait_done(input int d, input int exp_lat, input string tag);
    int cycles = 0;
    logic seen = 1'b0;
    while (!seen && cycles < 200) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      seen = (d == 1) ? done1 : done4;
    end
    check(tag, cycles, seen ? exp_lat : 32'hDEAD);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_result", result1, 32'd0);
    check("rst_zero", {31'd0, zero1}, 32'd0);
    check("rst_result4", result4, 32'd0);
    rst_n = 1'b1;

    // Basic ops, SLICE=1
    start_op(1, 2'b01, 32'hF0F0F0F0, 32'h0F0F0000);
    wait_done(1, 32, "lat_or");
    start_op(1, 2'b00, 32'h12345678, 32'h0000FFFF);
    wait_done(1, 32, "lat_and");
    start_op(1, 2'b10, 32'h12345678, 32'h0000FFFF);
    wait_done(1, 32, "lat_xor");
    start_op(1, 2'b11, 32'h00000000, 32'h00000000);
    wait_done(1, 32, "lat_nor");
    start_op(1, 2'b00, 32'hFFFF0000, 32'h0000FFFF);
    wait_done(1, 32, "lat_and_zero");
    start_op(1, 2'b10, 32'hA5A5C3C3, 32'h5A5AC3C3);
    wait_done(1, 32, "lat_xor2");

    // Starts while busy are ignored
    start_op(1, 2'b00, 32'hCAFEBABE, 32'hFFFF00FF);
    begin
      int cyc = 1;
      logic seen = 1'b0;
      while (!seen && cyc < 100) begin
        if (cyc == 5 || cyc == 20) drive(1, 1'b1, 2'b01, 32'h11111111, 32'h22222222);
        @(posedge clk);
        #1 start1 = 1'b0;
        @(negedge clk);
        seen = done1;
        if (!seen) cyc++;
      end
      check("lat_ignored_starts", cyc, seen ? 32 : 32'hDEAD);
    end
    repeat (40) @(negedge clk);
    check("idle_after_ignored", {31'd0, busy1}, 32'd0);

    // Reset mid-operation
    start_op(1, 2'b01, 32'h0F0F0F0F, 32'hF0000000);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    q1.delete();
    check("abort_busy", {31'd0, busy1}, 32'd0);
    check("abort_done", {31'd0, done1}, 32'd0);
    check("abort_result", result1, 32'd0);
    check("abort_zero", {31'd0, zero1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    start_op(1, 2'b11, 32'h0000FFFF, 32'h00FF0000);
    wait_done(1, 32, "lat_after_abort");

    // Back-to-back with start held, SLICE=1
    @(negedge clk);
    drive(1, 1'b1, 2'b10, 32'h12345678, 32'h0000FFFF);
    @(posedge clk);
    #1;
    push(1, 2'b10, 32'h12345678, 32'h0000FFFF);
    a1 = 32'hFFFF0000; b1 = 32'h00FFFF00; op1 = 2'b00;
    push(1, 2'b00, 32'hFFFF0000, 32'h00FFFF00);
    wait_done(1, 32, "b2b1_first");
    @(posedge clk);
    #1 start1 = 1'b0;
    check("b2b1_busy_reaccept", {31'd0, busy1}, 32'd1);
    begin
      int cyc = 1;
      logic seen = 1'b0;
      while (!seen && cyc < 100) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (cyc == 16) check("b2b1_result_held", result1, 32'h1234A987);
        seen = done1;
      end
      check("b2b1_gap", cyc, seen ? 33 : 32'hDEAD);
    end

    // SLICE=4
    start_op(4, 2'b01, 32'hF0F0F0F0, 32'h0F0F0000);
    wait_done(4, 8, "s4_lat_or");
    start_op(4, 2'b00, 32'hFFFF0000, 32'h0000FFFF);
    wait_done(4, 8, "s4_lat_and_zero");
    @(negedge clk);
    drive(4, 1'b1, 2'b11, 32'h0F0F0F0F, 32'h00000000);
    @(posedge clk);
    #1;
    push(4, 2'b11, 32'h0F0F0F0F, 32'h00000000);
    a4 = 32'h12345678; b4 = 32'h0000FFFF; op4 = 2'b10;
    push(4, 2'b10, 32'h12345678, 32'h0000FFFF);
    wait_done(4, 8, "b2b4_first");
    @(posedge clk);
    #1 start4 = 1'b0;
    begin
      int cyc = 1;
      logic seen = 1'b0;
      while (!seen && cyc < 100) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (cyc == 4) check("b2b4_result_held", result4, 32'hF0F0F0F0);
        seen = done4;
      end
      check("b2b4_gap", cyc, seen ? 9 : 32'hDEAD);
    end

    repeat (40) @(negedge clk);
    check("s1_queue_drained", q1.size(), 32'd0);
    check("s4_queue_drained", q4.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
